// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared constants, FSM state type and fetch fault helper for imem.
// Revision : 1.0  initial release
// ============================================================================
package imem_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_LOAD = 1'b1
   } imem_state_e;

   // A fetch faults when it is not word aligned or falls past the last word.
   function automatic logic fetch_is_fault(input logic [1:0]  byte_off,
                                           input logic [31:0] word_idx,
                                           input int unsigned depth);
      return (byte_off != 2'b00) || (word_idx >= depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module   : imem_ram
// Purpose  : Simple dual-port RAM, one write port, one registered read port.
// Revision : 1.0  initial release
// ============================================================================
module imem_ram
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       re,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [DATA_W-1:0]          rdata
);

   // Power-on contents only; the array itself is never reset.
   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: DATA_W'(NOP_INSTR)};
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= DATA_W'(NOP_INSTR);
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : imem_loadable
// Purpose  : Pipelined instruction memory with a run-time word-stream load port.
// Revision : 1.0  initial release
// ============================================================================
module imem_loadable
   import imem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 256
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_req,
   input  logic [ADDR_W-1:0]          fetch_addr,
   output logic                       fetch_valid,
   output logic [DATA_W-1:0]          fetch_instr,
   output logic                       fetch_fault,
   input  logic                       load_en,
   input  logic                       load_valid,
   input  logic [DATA_W-1:0]          load_data,
   output logic                       load_ready,
   output logic                       load_done,
   output logic [$clog2(DEPTH):0]     load_count,
   output logic                       busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   imem_state_e       state_q, state_d;
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              done_q, done_d;
   logic              fvalid_q, fvalid_d;
   logic              fault_q, fault_d;

   logic              in_load;
   logic              wr_en;
   logic              fault_now;
   logic              rd_en;
   logic [DATA_W-1:0] ram_rdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (load_en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!load_en) begin
               state_d = ST_RUN;
            end else if (load_valid && (wptr_q == AW'(DEPTH - 1))) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State outputs
   always_comb begin
      in_load    = (state_q == ST_LOAD);
      load_ready = in_load;
      busy       = in_load;
      wr_en      = in_load && load_en && load_valid;
   end

   // Datapath: pointer, counter, done pulse and fetch response bookkeeping
   always_comb begin
      fault_now = fetch_is_fault(fetch_addr[1:0], 32'(fetch_addr[ADDR_W-1:2]), DEPTH);
      fvalid_d  = fetch_req && (state_q == ST_RUN);
      rd_en     = fvalid_d && !fault_now;
      fault_d   = fvalid_d ? fault_now : fault_q;
      done_d    = in_load && (state_d == ST_RUN);
      wptr_d    = wptr_q;
      count_d   = count_q;
      if ((state_q == ST_RUN) && load_en) begin
         wptr_d  = '0;
         count_d = '0;
      end else if (wr_en) begin
         wptr_d  = wptr_q + AW'(1);
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q   <= '0;
         count_q  <= '0;
         done_q   <= 1'b0;
         fvalid_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         count_q  <= count_d;
         done_q   <= done_d;
         fvalid_q <= fvalid_d;
         fault_q  <= fault_d;
      end
   end

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_en),
      .waddr (wptr_q),
      .wdata (load_data),
      .re    (rd_en),
      .raddr (fetch_addr[AW+1:2]),
      .rdata (ram_rdata)
   );

   // The RAM is left untouched on a fault, so substitute NOP here.
   assign fetch_instr = fault_q ? DATA_W'(NOP_INSTR) : ram_rdata;
   assign fetch_valid = fvalid_q;
   assign fetch_fault = fault_q;
   assign load_done   = done_q;
   assign load_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loadable
// Purpose  : Randomised self-checking bench for imem_loadable.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loadable;

   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 16;
   localparam int          DEPTH  = 256;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_valid;
   logic [DATA_W-1:0] fetch_instr;
   logic              fetch_fault;
   logic              load_en;
   logic              load_valid;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              load_done;
   logic [8:0]        load_count;
   logic              busy;

   imem_loadable #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .fetch_instr (fetch_instr),
      .fetch_fault (fetch_fault),
      .load_en     (load_en),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .load_count  (load_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [31:0] ref_mem [DEPTH];
   bit          m_load;
   int          m_wptr;
   int          m_count;
   logic [31:0] m_instr;
   bit          m_fault;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: predict from current inputs, advance, then compare all outputs.
   task automatic cycle();
      bit exp_valid;
      bit exp_done;
      bit flt;
      int idx;
      exp_valid = fetch_req && !m_load;
      exp_done  = 1'b0;
      if (exp_valid) begin
         idx = int'(fetch_addr) / 4;
         flt = (fetch_addr % 4 != 0) || (idx >= DEPTH);
         m_fault = flt;
         m_instr = flt ? NOP : ref_mem[idx];
      end
      if (!m_load) begin
         if (load_en) begin
            m_load  = 1'b1;
            m_wptr  = 0;
            m_count = 0;
         end
      end else if (!load_en) begin
         m_load   = 1'b0;
         exp_done = 1'b1;
      end else if (load_valid) begin
         ref_mem[m_wptr] = load_data;
         m_wptr++;
         m_count++;
         if (m_count == DEPTH) begin
            m_load   = 1'b0;
            exp_done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check("fetch_valid", 64'(fetch_valid), 64'(exp_valid));
      check("fetch_instr", 64'(fetch_instr), 64'(m_instr));
      check("fetch_fault", 64'(fetch_fault), 64'(m_fault));
      check("load_ready",  64'(load_ready),  64'(m_load));
      check("busy",        64'(busy),        64'(m_load));
      check("load_done",   64'(load_done),   64'(exp_done));
      check("load_count",  64'(load_count),  64'(m_count));
   endtask

   task automatic idle_inputs();
      fetch_req  = 1'b0;
      fetch_addr = '0;
      load_en    = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
   endtask

   task automatic check_reset_values();
      check("rst_fetch_valid", 64'(fetch_valid), 64'd0);
      check("rst_fetch_instr", 64'(fetch_instr), 64'(NOP));
      check("rst_fetch_fault", 64'(fetch_fault), 64'd0);
      check("rst_load_ready",  64'(load_ready),  64'd0);
      check("rst_load_done",   64'(load_done),   64'd0);
      check("rst_load_count",  64'(load_count),  64'd0);
      check("rst_busy",        64'(busy),        64'd0);
   endtask

   // Asynchronous reset asserted between edges; memory contents survive.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      m_load  = 1'b0;
      m_wptr  = 0;
      m_count = 0;
      m_instr = NOP;
      m_fault = 1'b0;
      check_reset_values();
      @(posedge clk);
      #1;
      check_reset_values();
      rst_n = 1'b1;
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] a);
      fetch_req  = 1'b1;
      fetch_addr = a;
      cycle();
      fetch_req  = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      case ($urandom_range(0, 3))
         0:       return ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
         1:       return ADDR_W'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
         2:       return ADDR_W'($urandom_range(DEPTH * 4, 16'hFFFF));
         default: return ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
      endcase
   endfunction

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = NOP;
      idle_inputs();
      rst_n = 1'b1;
      #2;
      apply_reset();

      // Default contents
      fetch(16'h0000);
      cycle();

      // Small load then back-to-back fetches
      load_en = 1'b1;
      cycle();
      load_valid = 1'b1; load_data = 32'h00c0_0513; cycle();
      load_valid = 1'b0; cycle();
      load_valid = 1'b1; load_data = 32'h0090_0593; cycle();
      load_data  = 32'h40b5_0633; cycle();
      load_en    = 1'b0; load_data = 32'hDEAD_BEEF; cycle();
      load_valid = 1'b0; cycle();
      fetch_req = 1'b1;
      fetch_addr = 16'h0000; cycle();
      fetch_addr = 16'h0004; cycle();
      fetch_addr = 16'h0008; cycle();
      fetch_addr = 16'h000C; cycle();
      fetch_req = 1'b0;
      cycle();

      // Faulting and boundary fetches, then hold with no request
      fetch(16'h0006);
      fetch(16'h0400);
      fetch(16'h03FC);
      fetch(16'h0006);
      cycle();
      cycle();

      // Full load with gaps; fetch requested throughout, including entry cycle
      fetch_req  = 1'b1;
      fetch_addr = 16'h0004;
      load_en    = 1'b1;
      cycle();
      for (int n = 0; n < DEPTH; ) begin
         fetch_addr = rand_addr();
         load_valid = ($urandom_range(0, 3) != 0);
         load_data  = $urandom;
         if (load_valid) n++;
         cycle();
      end
      load_valid = 1'b0;
      fetch_req  = 1'b0;
      cycle();
      cycle();
      load_en = 1'b0;
      for (int i = 0; i < 20; i++) fetch(rand_addr());
      fetch(16'h03FC);

      // Reset after five words written
      load_en = 1'b1;
      cycle();
      load_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         load_data = $urandom;
         cycle();
      end
      load_valid = 1'b0;
      #3;
      apply_reset();
      load_en = 1'b0;
      for (int i = 0; i < 7; i++) fetch(ADDR_W'(i * 4));

      // Random mixed traffic with short loads
      for (int i = 0; i < 400; i++) begin
         fetch_req  = ($urandom_range(0, 3) != 0);
         fetch_addr = rand_addr();
         if ($urandom_range(0, 29) == 0) load_en = ~load_en;
         load_valid = $urandom_range(0, 1);
         load_data  = $urandom;
         cycle();
      end
      idle_inputs();
      cycle();
      cycle();
      for (int i = 0; i < DEPTH; i++) fetch(ADDR_W'(i * 4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
